// File: rtl/servo_pwm_ramp.sv
// Frame-based servo PWM generator: one pulse per frame, pulse width slewed toward a clamped
// target by at most one step per frame, with configuration shadowed until the frame boundary.
module servo_pwm_ramp #(
    parameter int CNT_W      = 21,
    parameter int DEF_PERIOD = 2_000_000,
    parameter int MIN_PULSE  = 100_000,
    parameter int MAX_PULSE  = 200_000
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             cfg_enable,
    input  logic             cfg_load,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [CNT_W-1:0] cfg_step,
    output logic             pwm_out,
    output logic [CNT_W-1:0] cur_pulse,
    output logic             busy,
    output logic             frame_tick
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] DEF_P     = CNT_W'(DEF_PERIOD);
    localparam logic [CNT_W-1:0] MIN_P     = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W-1:0] MAX_P     = CNT_W'(MAX_PULSE);
    localparam logic [CNT_W-1:0] MIN_FRAME = CNT_W'(MAX_PULSE + 1);
    localparam logic [CNT_W-1:0] ZERO      = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] ONE       = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [CNT_W-1:0] norm_period(input logic [CNT_W-1:0] p);
        norm_period = (p == ZERO) ? DEF_P : p;
    endfunction

    function automatic logic [CNT_W-1:0] clamp_target(input logic [CNT_W-1:0] t);
        if (t < MIN_P) begin
            clamp_target = MIN_P;
        end else if (t > MAX_P) begin
            clamp_target = MAX_P;
        end else begin
            clamp_target = t;
        end
    endfunction

    // Difference is taken one bit wider so cur+step can never wrap past the target.
    function automatic logic [CNT_W-1:0] slew_toward(input logic [CNT_W-1:0] cur,
                                                     input logic [CNT_W-1:0] tgt,
                                                     input logic [CNT_W-1:0] step);
        logic [CNT_W:0] diff;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
        end else begin
            diff = {1'b0, cur} - {1'b0, tgt};
        end
        if ((step == ZERO) || (diff <= {1'b0, step})) begin
            slew_toward = tgt;
        end else if (tgt > cur) begin
            slew_toward = cur + step;
        end else begin
            slew_toward = cur - step;
        end
    endfunction

    logic [1:0]       state_r, state_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic [CNT_W-1:0] act_period_r, act_target_r, act_step_r;
    logic [CNT_W-1:0] act_period_s, act_target_s, act_step_s;
    logic [CNT_W-1:0] pend_period_r, pend_target_r, pend_step_r;
    logic [CNT_W-1:0] pend_period_s, pend_target_s, pend_step_s;
    logic             pend_valid_r, pend_valid_s;
    logic [CNT_W-1:0] cur_pulse_s;
    logic             pwm_s, tick_s, busy_s;
    logic             apply_s, slew_s, last_s;
    logic [CNT_W-1:0] eff_period_s;

    // Next-state logic: frame sequencing, shadow apply and pulse slewing.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        apply_s = 1'b0;
        slew_s  = 1'b0;
        pwm_s   = 1'b0;
        tick_s  = 1'b0;
        eff_period_s = (act_period_r < MIN_FRAME) ? MIN_FRAME : act_period_r;
        last_s  = (cnt_r == (eff_period_s - ONE));

        case (state_r)
            ST_IDLE: begin
                cnt_s = ZERO;
                if (cfg_enable) begin
                    state_s = ST_RUN;
                    apply_s = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                pwm_s = (cnt_r < cur_pulse);
                if (last_s) begin
                    tick_s  = 1'b1;
                    cnt_s   = ZERO;
                    apply_s = 1'b1;
                    slew_s  = 1'b1;
                    state_s = cfg_enable ? ST_RUN : ST_IDLE;
                end else begin
                    cnt_s   = cnt_r + ONE;
                    state_s = cfg_enable ? ST_RUN : ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = ZERO;
            end
        endcase

        if (apply_s && pend_valid_r) begin
            act_period_s = pend_period_r;
            act_target_s = pend_target_r;
            act_step_s   = pend_step_r;
        end else begin
            act_period_s = act_period_r;
            act_target_s = act_target_r;
            act_step_s   = act_step_r;
        end

        // A load on the boundary cycle stays pending for the following boundary.
        if (cfg_load) begin
            pend_period_s = norm_period(cfg_period);
            pend_target_s = clamp_target(cfg_target);
            pend_step_s   = cfg_step;
            pend_valid_s  = 1'b1;
        end else begin
            pend_period_s = pend_period_r;
            pend_target_s = pend_target_r;
            pend_step_s   = pend_step_r;
            pend_valid_s  = (apply_s && pend_valid_r) ? 1'b0 : pend_valid_r;
        end

        if (slew_s) begin
            cur_pulse_s = slew_toward(cur_pulse, act_target_s, act_step_s);
        end else begin
            cur_pulse_s = cur_pulse;
        end

        busy_s = (cur_pulse_s != act_target_s) | pend_valid_s;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_r       <= ST_IDLE;
            cnt_r         <= ZERO;
            act_period_r  <= DEF_P;
            act_target_r  <= MIN_P;
            act_step_r    <= ZERO;
            pend_period_r <= DEF_P;
            pend_target_r <= MIN_P;
            pend_step_r   <= ZERO;
            pend_valid_r  <= 1'b0;
            cur_pulse     <= MIN_P;
            pwm_out       <= 1'b0;
            frame_tick    <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            act_period_r  <= act_period_s;
            act_target_r  <= act_target_s;
            act_step_r    <= act_step_s;
            pend_period_r <= pend_period_s;
            pend_target_r <= pend_target_s;
            pend_step_r   <= pend_step_s;
            pend_valid_r  <= pend_valid_s;
            cur_pulse     <= cur_pulse_s;
            pwm_out       <= pwm_s;
            frame_tick    <= tick_s;
            busy          <= busy_s;
        end
    end

endmodule
